vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing_if.sv | 14 +
 rtl/vga_timing.sv | 93 +++++++++
 tb/tb_vga_timing.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Video timing bundle: pixel counters plus sync/blanking/strobe flags.
// The timing generator drives it through master; a pixel pipeline reads it through slave.
interface vga_timing_if;
  logic [9:0] col;
  logic [9:0] row;
  logic       hsync;
  logic       vsync;
  logic       visible;
  logic       pixel_en;
  logic       frame_start;

  modport master (output col, row, hsync, vsync, visible, pixel_en, frame_start);
  modport slave  (input  col, row, hsync, vsync, visible, pixel_en, frame_start);
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator: free-running col/row counters with registered sync and blanking flags.
// Define VGA_TIMING_PIXEL_DIV2_EN to advance one pixel every second clk (e.g. 50 MHz clk, 25 MHz pixel).
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic         clk,
  input  logic         reset_n,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] col_q, row_q;
  logic [9:0] col_next, row_next;
  logic       hsync_q, vsync_q, visible_q, pixel_en_q, frame_start_q;
  logic       tick;

`ifdef VGA_TIMING_PIXEL_DIV2_EN
  logic phase_q;

  // Phase 0 is the first clk of a pixel, so the first edge out of reset is a tick.
  always_ff @(posedge clk) begin
    if (!reset_n) phase_q <= 1'b0;
    else          phase_q <= ~phase_q;
  end

  assign tick = ~phase_q;
`else
  assign tick = 1'b1;
`endif

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    col_next = col_q;
    row_next = row_q;
    if (tick) begin
      if (col_q == H_LAST) begin
        col_next = '0;
        row_next = (row_q == V_LAST) ? '0 : row_q + 10'd1;
      end else begin
        col_next = col_q + 10'd1;
      end
    end
  end

  // Flags are decoded from the next counter values so they land in the same cycle as the col/row they describe.
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_q         <= H_LAST;
      row_q         <= V_LAST;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      visible_q     <= 1'b0;
      pixel_en_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      col_q         <= col_next;
      row_q         <= row_next;
      hsync_q       <= !((col_next >= HS_START) && (col_next < HS_END));
      vsync_q       <= !((row_next >= VS_START) && (row_next < VS_END));
      visible_q     <= (col_next < H_VIS) && (row_next < V_VIS);
      pixel_en_q    <= tick;
      frame_start_q <= tick && (col_next == '0) && (row_next == '0);
    end
  end

  assign vga.col         = col_q;
  assign vga.row         = row_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.visible     = visible_q;
  assign vga.pixel_en    = pixel_en_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: a default 640x480 instance for the line-level checks and a
// shrunken-raster instance (25 x 19) so that whole frames fit in a short run.
module tb_vga_timing;

`ifdef VGA_TIMING_PIXEL_DIV2_EN
  localparam int CPP = 2;
`else
  localparam int CPP = 1;
`endif

  // Small raster: H 16+2+4+3 = 25 (hsync low cols 18..21), V 12+2+2+3 = 19 (vsync low rows 14..15).
  localparam int S_HT    = 25;
  localparam int S_VT    = 19;
  localparam int S_FRAME = S_HT * S_VT;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_timing_if vd ();
  vga_timing_if vs ();

  vga_timing dut_full (
    .clk     (clk),
    .reset_n (reset_n),
    .vga     (vd)
  );

  vga_timing #(
    .H_VISIBLE (16),
    .H_FRONT   (2),
    .H_SYNC    (4),
    .H_BACK    (3),
    .V_VISIBLE (12),
    .V_FRONT   (2),
    .V_SYNC    (2),
    .V_BACK    (3)
  ) dut_small (
    .clk     (clk),
    .reset_n (reset_n),
    .vga     (vs)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("full.rst.col",      32'(vd.col),   799);
    check("full.rst.row",      32'(vd.row),   524);
    check("full.rst.hsync",    32'(vd.hsync), 1);
    check("full.rst.vsync",    32'(vd.vsync), 1);
    check("full.rst.visible",  32'(vd.visible), 0);
    check("full.rst.pixel_en", 32'(vd.pixel_en), 0);
    check("full.rst.fstart",   32'(vd.frame_start), 0);
    check("small.rst.col",     32'(vs.col),   S_HT - 1);
    check("small.rst.row",     32'(vs.row),   S_VT - 1);
    check("small.rst.hsync",   32'(vs.hsync), 1);
    check("small.rst.vsync",   32'(vs.vsync), 1);
    check("small.rst.visible", 32'(vs.visible), 0);
    check("small.rst.fstart",  32'(vs.frame_start), 0);
  endtask

  task automatic check_first_tick();
    check("full.first.col",      32'(vd.col), 0);
    check("full.first.row",      32'(vd.row), 0);
    check("full.first.visible",  32'(vd.visible), 1);
    check("full.first.fstart",   32'(vd.frame_start), 1);
    check("full.first.pixel_en", 32'(vd.pixel_en), 1);
    check("small.first.col",     32'(vs.col), 0);
    check("small.first.row",     32'(vs.row), 0);
    check("small.first.visible", 32'(vs.visible), 1);
    check("small.first.fstart",  32'(vs.frame_start), 1);
  endtask

  initial begin
    int hs_low  = 0;
    int vs_low  = 0;
    int last_fs = -1;

    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_reset_values();

    reset_n = 1'b1;
    for (int k = 0; k < 1010 * CPP; k++) begin
      int p, ph, fc, fr, sc, sr;
      step();
      p  = k / CPP;
      ph = k % CPP;
      fc = p % 800;
      fr = p / 800;
      sc = p % S_HT;
      sr = (p / S_HT) % S_VT;

      check("full.col",      32'(vd.col), fc);
      check("full.row",      32'(vd.row), fr);
      check("full.hsync",    32'(vd.hsync), (fc >= 656 && fc < 752) ? 0 : 1);
      check("full.visible",  32'(vd.visible), (fc < 640 && fr < 480) ? 1 : 0);
      check("full.pixel_en", 32'(vd.pixel_en), (ph == 0) ? 1 : 0);
      check("full.fstart",   32'(vd.frame_start), (k == 0) ? 1 : 0);

      check("small.col",     32'(vs.col), sc);
      check("small.row",     32'(vs.row), sr);
      check("small.hsync",   32'(vs.hsync), (sc >= 18 && sc < 22) ? 0 : 1);
      check("small.vsync",   32'(vs.vsync), (sr >= 14 && sr < 16) ? 0 : 1);
      check("small.visible", 32'(vs.visible), (sc < 16 && sr < 12) ? 1 : 0);
      check("small.fstart",  32'(vs.frame_start), (ph == 0 && p % S_FRAME == 0) ? 1 : 0);

      if (k < 800 * CPP && !vd.hsync) hs_low++;
      if (k < S_FRAME * CPP && !vs.vsync) vs_low++;
      if (vs.frame_start) begin
        if (last_fs >= 0) check("small.frame_period", 32'(k - last_fs), S_FRAME * CPP);
        last_fs = k;
      end
    end

    check("full.hsync_low_clks",  32'(hs_low), 96 * CPP);
    check("small.vsync_low_clks", 32'(vs_low), 2 * S_HT * CPP);

    // Small raster now sits mid-frame at (9,2); reset must abort without finishing the line.
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_reset_values();
    end
    reset_n = 1'b1;
    step();
    check_first_tick();

`ifdef VGA_TIMING_PIXEL_DIV2_EN
    step();
    check("full.div2.hold_col",   32'(vd.col), 0);
    check("full.div2.pixel_en",   32'(vd.pixel_en), 0);
    check("full.div2.fstart_off", 32'(vd.frame_start), 0);
    step();
    check("full.div2.next_col",   32'(vd.col), 1);
    check("full.div2.pixel_en_1", 32'(vd.pixel_en), 1);
`else
    step();
    check("full.next_col",      32'(vd.col), 1);
    check("full.pixel_en_cont", 32'(vd.pixel_en), 1);
    check("full.fstart_off",    32'(vd.frame_start), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
